// File: rtl/sine_tdm_sched.sv
// Time-division scheduler that shares one sine_gen lookup among NCH oscillator channels.
// A frame issues one phase word per clock, then realigns the returned sin/cos words to their
// channels and publishes all channels together with a one-cycle done strobe.
module sine_tdm_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned fsz = 24,
  parameter int unsigned psz = 12,
  parameter int unsigned osz = 18,
  parameter int unsigned LAT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    wr,
  input  logic [$clog2(NCH)-1:0]  wr_ch,
  input  logic [fsz-1:0]          wr_data,
  output logic [psz-1:0]          phs,
  input  logic signed [osz-1:0]   sin_in,
  input  logic signed [osz-1:0]   cos_in,
  output logic [NCH*osz-1:0]      sin_out,
  output logic [NCH*osz-1:0]      cos_out,
  output logic                    done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned SW = $clog2(NCH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic [SW-1:0]     r_slot, w_slot_d;

  logic [fsz-1:0]    r_sh  [NCH];
  logic [fsz-1:0]    r_ai  [NCH];
  logic [fsz-1:0]    r_acc [NCH];
  logic [psz-1:0]    r_phs;

  // Slot tags travelling alongside the sine_gen pipeline
  logic [LAT-1:0]    r_pv;
  logic [SW-1:0]     r_ps [LAT];

  // Last slot bypasses holding straight to the outputs, so only NCH-1 holding entries
  logic [osz-1:0]    r_hs [NCH-1];
  logic [osz-1:0]    r_hc [NCH-1];
  logic [NCH*osz-1:0] r_sin_out, r_cos_out;
  logic              r_done;
  logic              r_ovr;

  logic              w_accept;
  logic              w_issue;
  logic              w_cap;
  logic              w_last;

  assign w_accept = (r_state == StIdle) && tick;
  assign w_issue  = (r_state == StIssue);
  assign w_cap    = r_pv[LAT-1];
  assign w_last   = w_cap && (r_ps[LAT-1] == SW'(NCH - 1));

  assign phs     = r_phs;
  assign sin_out = r_sin_out;
  assign cos_out = r_cos_out;
  assign done    = r_done;
  assign busy    = (r_state != StIdle);
  assign overrun = r_ovr;

  // FSM state and slot register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_d;
      r_slot  <= w_slot_d;
    end
  end

  // FSM next state: idle -> issue one slot per cycle -> drain until last capture
  always_comb begin
    w_state_d = r_state;
    w_slot_d  = r_slot;
    case (r_state)
      StIdle: begin
        if (tick) begin
          w_state_d = StIssue;
          w_slot_d  = '0;
        end
      end
      StIssue: begin
        if (r_slot == SW'(NCH - 1)) begin
          w_state_d = StDrain;
        end else begin
          w_slot_d = r_slot + SW'(1);
        end
      end
      StDrain: begin
        if (w_last) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Per-channel shadow/active increments and phase accumulators
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NCH); k++) begin
        r_sh[k]  <= '0;
        r_ai[k]  <= '0;
        r_acc[k] <= '0;
      end
    end else begin
      // Active increments latch from the shadows before a same-edge write lands
      if (w_accept) begin
        for (int k = 0; k < int'(NCH); k++) begin
          r_ai[k] <= r_sh[k];
        end
      end
      if (w_issue) begin
        r_acc[r_slot] <= r_acc[r_slot] + r_ai[r_slot];
      end
      if (wr && (int'(wr_ch) < int'(NCH))) begin
        r_sh[wr_ch] <= wr_data;
      end
    end
  end

  // Phase word to sine_gen: slot 0 loads on the accepting edge, then one slot per edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phs <= '0;
    end else if (w_accept) begin
      r_phs <= r_acc[0][fsz-1 -: psz];
    end else if (w_issue && (r_slot != SW'(NCH - 1))) begin
      r_phs <= r_acc[r_slot + SW'(1)][fsz-1 -: psz];
    end
  end

  // Slot tag pipeline matching the sine_gen latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv <= '0;
      for (int i = 0; i < int'(LAT); i++) begin
        r_ps[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_issue;
      r_ps[0] <= r_slot;
      for (int i = 1; i < int'(LAT); i++) begin
        r_pv[i] <= r_pv[i-1];
        r_ps[i] <= r_ps[i-1];
      end
    end
  end

  // Capture returned words; publish the whole frame at once on the last capture
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NCH) - 1; k++) begin
        r_hs[k] <= '0;
        r_hc[k] <= '0;
      end
      r_sin_out <= '0;
      r_cos_out <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_cap && !w_last) begin
        r_hs[r_ps[LAT-1]] <= sin_in;
        r_hc[r_ps[LAT-1]] <= cos_in;
      end
      if (w_last) begin
        for (int k = 0; k < int'(NCH) - 1; k++) begin
          r_sin_out[k*osz +: osz] <= r_hs[k];
          r_cos_out[k*osz +: osz] <= r_hc[k];
        end
        r_sin_out[(NCH-1)*osz +: osz] <= sin_in;
        r_cos_out[(NCH-1)*osz +: osz] <= cos_in;
      end
    end
  end

  // Sticky overrun: a tick that arrives while a frame is in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovr <= 1'b0;
    end else if (tick && (r_state != StIdle)) begin
      r_ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sine_tdm_sched.sv
// Self-checking bench for sine_tdm_sched with a 3-stage stub sine_gen and a frame-level model.
module tb_sine_tdm_sched;

  localparam int NCH = 4;
  localparam int FSZ = 24;
  localparam int PSZ = 12;
  localparam int OSZ = 18;
  localparam int LAT = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   tick = 1'b0;
  logic                   wr = 1'b0;
  logic [1:0]             wr_ch = '0;
  logic [FSZ-1:0]         wr_data = '0;
  logic [PSZ-1:0]         phs;
  logic signed [OSZ-1:0]  sin_in;
  logic signed [OSZ-1:0]  cos_in;
  logic [NCH*OSZ-1:0]     sin_out;
  logic [NCH*OSZ-1:0]     cos_out;
  logic                   done;
  logic                   busy;
  logic                   overrun;

  sine_tdm_sched #(
    .NCH (NCH),
    .fsz (FSZ),
    .psz (PSZ),
    .osz (OSZ),
    .LAT (LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .wr      (wr),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .phs     (phs),
    .sin_in  (sin_in),
    .cos_in  (cos_in),
    .sin_out (sin_out),
    .cos_out (cos_out),
    .done    (done),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Stub sine_gen: three register stages, sin = zero-extended phase, cos = its complement
  logic [PSZ-1:0] sg1 = '0, sg2 = '0, sg3 = '0;
  always @(posedge clk) begin
    sg1 <= phs;
    sg2 <= sg1;
    sg3 <= sg2;
  end
  assign sin_in = {6'b0, sg3};
  assign cos_in = ~{6'b0, sg3};

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model
  int unsigned        m_sh  [NCH];
  int unsigned        m_ai  [NCH];
  int unsigned        m_acc [NCH];
  logic [NCH*OSZ-1:0] m_fs = '0, m_fc = '0, m_sin = '0, m_cos = '0;
  bit                 m_busy = 0, m_done = 0, m_ovr = 0;
  int                 m_cnt = 0;

  task automatic chk(input string tag, input logic [NCH*OSZ-1:0] got,
                     input logic [NCH*OSZ-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_sh[k] = 0; m_ai[k] = 0; m_acc[k] = 0;
    end
    m_sin = '0; m_cos = '0; m_busy = 0; m_done = 0; m_ovr = 0; m_cnt = 0;
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later
  task automatic step(input bit t, input bit w, input int c, input int unsigned d, input bit r);
    int unsigned ph;
    tick = t; wr = w; wr_ch = 2'(c); wr_data = 24'(d); reset = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (t) m_ovr = 1;
        m_cnt++;
        if (m_cnt == NCH + LAT) begin
          m_busy = 0; m_done = 1; m_sin = m_fs; m_cos = m_fc;
        end
      end else if (t) begin
        for (int k = 0; k < NCH; k++) begin
          ph = m_acc[k] >> (FSZ - PSZ);
          m_fs[k*OSZ +: OSZ] = 18'(ph);
          m_ai[k] = m_sh[k];
          m_acc[k] = (m_acc[k] + m_ai[k]) % (32'd1 << FSZ);
        end
        m_fc = ~m_fs;
        m_busy = 1; m_cnt = 0;
      end
      if (w) m_sh[c] = d % (32'd1 << FSZ);
    end
    #1;
    chk("done", {71'b0, done}, {71'b0, m_done});
    chk("busy", {71'b0, busy}, {71'b0, m_busy});
    chk("overrun", {71'b0, overrun}, {71'b0, m_ovr});
    chk("sin_out", sin_out, m_sin);
    chk("cos_out", cos_out, m_cos);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic frame();
    step(1, 0, 0, 0, 0);
    idle(7);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset state
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

    // Basic frames: increments 4096*(k+1) -> sin 0, {1..4}, {2..8}
    for (int k = 0; k < NCH; k++) step(0, 1, k, 4096 * (k + 1), 0);
    for (int f = 0; f < 3; f++) frame();
    chk("frame3_sin", sin_out, {18'd8, 18'd6, 18'd4, 18'd2});

    // Accumulator wrap on ch0 with increment 2^23
    step(0, 1, 0, 32'h800000, 0);
    for (int k = 1; k < NCH; k++) step(0, 1, k, 0, 0);
    for (int f = 0; f < 6; f++) frame();

    // Tick at E0+7 dropped and sets overrun; tick at E0+8 accepted
    step(1, 0, 0, 0, 0);
    idle(6);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(7);
    chk("overrun_sticky", {71'b0, overrun}, 72'd1);

    // Write coincident with accepted tick misses that frame
    for (int k = 0; k < NCH; k++) step(0, 1, k, 0, 0);
    step(1, 1, 1, 4096, 0);
    idle(7);
    for (int f = 0; f < 3; f++) frame();

    // Reset at E0+4 aborts the frame; next frame starts from zero
    step(1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1);
    idle(4);
    for (int k = 0; k < NCH; k++) step(0, 1, k, 4096 * (k + 2), 0);
    frame();
    frame();

    // Write during drain takes effect on the following frame
    step(1, 0, 0, 0, 0);
    idle(4);
    step(0, 1, 2, 32'h100000, 0);
    idle(2);
    frame();
    frame();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
           $urandom & 32'hFFFFFF, ($urandom_range(0, 79) == 0));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_tdm_sched.md
# sine_tdm_sched

Time-division scheduler that shares one `sine_gen` lookup among `NCH` oscillator channels. On each sample tick it advances every channel's phase accumulator and issues one phase word per clock to the shared `sine_gen`. It then realigns the returned sine and cosine words to their channels, compensating for the fixed lookup latency. It presents a coherent per-channel sin/cos frame to the DAC side with a one-cycle `done` strobe.

## Interface
Parameters:
- `NCH`, 4: number of oscillator channels (TDM slots), ≥ 2.
- `fsz`, 24: phase accumulator / frequency word width.
- `psz`, 12: phase word width sent to `sine_gen` (top `psz` bits of accumulator).
- `osz`, 18: sin/cos word width.
- `LAT`, 3: `sine_gen` latency, edges from phase sampled to sin/cos valid.

Ports:
- `clk` in 1: main system clock.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: sample-rate strobe; starts a frame when not busy.
- `wr` in 1: frequency-word write enable.
- `wr_ch` in clog2(NCH): channel to write.
- `wr_data` in fsz: unsigned phase increment.
- `phs` out psz: phase to `sine_gen`, registered.
- `sin_in`, `cos_in` in osz signed: from `sine_gen`.
- `sin_out`, `cos_out` out NCH*osz: channel k at bits [k*osz +: osz], signed.
- `done` out 1: one-cycle pulse; new frame on outputs.
- `busy` out 1: frame in progress.
- `overrun` out 1: sticky; tick arrived while busy.

## Operation
- Per channel: shadow increment `sh[k]`, active increment `ai[k]`, accumulator `acc[k]` (fsz bits, wraps modulo 2^fsz).
- A write with `wr=1` sets `sh[wr_ch] <= wr_data` at any time, busy or not. The write is never lost. It takes effect at the next accepted tick.
- FSM states:
  - IDLE: on `tick` → ISSUE with slot 0. At that edge, `ai[k] <= sh[k]` for all k. A write on the same edge lands in `sh` but misses this frame.
  - ISSUE: slot s = 0..NCH-1, one slot per cycle. `phs = acc[s][fsz-1 -: psz]`. At the end of slot s, `acc[s] <= acc[s] + ai[s]`. After slot NCH-1 → DRAIN.
  - DRAIN: waits until the last capture, then → IDLE, asserting `done`.
- Capture: returned data for slot s is captured into holding register s. All NCH output pairs update together on the edge that raises `done`, so outputs never show a mixed frame. Slot NCH-1 may bypass holding straight to the output.
- `tick` while busy is dropped and sets `overrun`. Only `reset` clears `overrun`.
- `tick` while `busy=0` always starts a frame, including in the cycle `done` is high.

## Timing
- Edge E0 accepts `tick`. After E0+k (k=0..NCH-1), `phs` = phase of channel k. `sine_gen` samples it at E0+k+1. Data is valid after E0+k+1+LAT-1 and is captured at edge E0+k+LAT+1.
- Outputs and `done=1` take effect at edge E0+NCH+LAT; with the defaults this is E0+7. `done` is high for exactly one cycle.
- `busy` is 1 from after E0 until the edge that raises `done`, where it falls.
- The minimum accepted tick period is NCH+LAT+1 = 8 cycles. A tick at E0+7 is dropped and sets `overrun`. A tick at E0+8 is accepted.
- `phs` holds its last value outside ISSUE.
- Reset values: `acc`, `sh`, `ai`, holding regs, `sin_out`, `cos_out`, and `phs` are 0. `busy`, `done`, and `overrun` are 0. State is IDLE.
- Reset mid-frame aborts immediately. There is no `done` pulse and outputs are zeroed. `tick` coincident with `reset` is ignored.

## Test plan
Use a stub `sine_gen` with a 3-stage pipeline returning `sin_in = {0, phs}` and `cos_in = ~{0, phs}`.
- Reset, write `sh = {4096, 8192, 12288, 16384}`, then tick every 8 cycles. Frame 1 outputs all sin=0. Frame 2 sin = {1, 2, 3, 4}. Frame 3 sin = {2, 4, 6, 8}. `done` is high exactly at E0+7. cos is the bitwise complement of sin in every frame.
- Ch0 inc = 2^23, 6 frames → ch0 sin sequence 0, 2048, 0, 2048, …, exercising accumulator wrap.
- Tick at E0+7 → dropped, `overrun=1`, no extra `done`. Tick at E0+8 → accepted, `overrun` stays 1.
- `wr` ch1 = 4096 on the same edge as an accepted tick → ch1 does not advance at the end of that frame. It advances by 1 per frame from the next frame onward.
- `reset` at E0+4 → no `done`, all outputs 0, `busy=0`. The next tick yields a sin=0 frame.
- Write during DRAIN → takes effect next frame. The current frame's outputs are unaffected.
